// File: rtl/riscv_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; the low bits of a target are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/riscv_fetch_queue_if.sv
// Fetch front-end bundle: imem request/response channel, redirect/stall control and IF/ID outputs.
interface riscv_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             stall;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic [LVL_W-1:0] queue_level;

  // The fetch unit drives requests and the IF/ID side.
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, queue_level,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, stall
  );

  // Memory, hazard unit and IF/ID register as seen from outside the fetch unit.
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, queue_level,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, stall
  );

endinterface

// File: rtl/riscv_fetch_queue_fifo.sv
// Synchronous FIFO with flush; head word is visible combinationally on rdata_o.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_en, pop_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_en) - LW'(pop_en);
    end
  end

  // NOTE: storage is not reset; the level counter guarantees no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (push_en && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests and queues returned words for IF/ID.
// Build option IF_BYPASS_EN forwards a response straight to IF/ID in the same cycle when the queue is empty.
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 reset,
  riscv_fetch_queue_if.master bus
);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  fetch_state_t  state_q;
  logic [31:0]   fetch_pc_q;
  logic          req_valid_q;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t  q_wdata, q_rdata;
  logic          q_push, q_pop, q_full, q_empty;
  logic [CW-1:0] q_level;

  logic [31:0]   pc_head;
  logic          pc_push, pc_pop, pc_full, pc_empty;
  logic [CW-1:0] pc_level;

  logic          hs, rsp_live, rsp_stale, bypass, credit_ok;
  logic [CW-1:0] queue_level_d, outstanding_d;
  logic [CW:0]   credit_sum;

  assign hs        = req_valid_q && bus.imem_req_ready;
  assign rsp_live  = bus.imem_rsp_valid && (state_q == FETCH) && !pc_empty;
  assign rsp_stale = bus.imem_rsp_valid && (state_q == DRAIN) && (drop_cnt_q != '0);

`ifdef IF_BYPASS_EN
  assign bypass = rsp_live && q_empty && !bus.stall && !bus.redirect;
`else
  assign bypass = 1'b0;
`endif

  // A response in a redirect cycle is dropped; the flush wins over push and pop.
  assign q_push  = rsp_live && !bus.redirect && !bypass && !q_full;
  assign q_pop   = !q_empty && !bus.stall && !bus.redirect;
  assign q_wdata = '{instr: bus.imem_rsp_data, pc: pc_head};
  assign pc_push = hs && !pc_full;
  assign pc_pop  = rsp_live;

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_instr_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .flush_i(bus.redirect),
    .push_i (q_push),
    .pop_i  (q_pop),
    .wdata_i(q_wdata),
    .rdata_o(q_rdata),
    .full_o (q_full),
    .empty_o(q_empty),
    .level_o(q_level)
  );

  // PCs of accepted requests, in order; its level is the outstanding-request count.
  fetch_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_pc_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .flush_i(bus.redirect),
    .push_i (pc_push),
    .pop_i  (pc_pop),
    .wdata_i(fetch_pc_q),
    .rdata_o(pc_head),
    .full_o (pc_full),
    .empty_o(pc_empty),
    .level_o(pc_level)
  );

  always_comb begin
    queue_level_d = bus.redirect ? '0 : q_level + CW'(q_push) - CW'(q_pop);
    outstanding_d = bus.redirect ? '0 : pc_level + CW'(pc_push) - CW'(pc_pop);
    credit_sum    = {1'b0, queue_level_d} + {1'b0, outstanding_d};
    credit_ok     = credit_sum < {1'b0, DEPTH_CW};
    drop_cnt_d    = drop_cnt_q;
    if (state_q == DRAIN) begin
      drop_cnt_d = drop_cnt_q - CW'(rsp_stale);
    end else if (bus.redirect) begin
      // Everything in flight becomes stale, including a request accepted this very cycle.
      drop_cnt_d = pc_level + CW'(hs) - CW'(rsp_live);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (bus.redirect)  fetch_pc_q <= align_word(bus.redirect_pc);
      else if (hs)       fetch_pc_q <= fetch_pc_q + 32'd4;
      case (state_q)
        FETCH: begin
          if (drop_cnt_d != '0) begin
            state_q     <= DRAIN;
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= credit_ok;
          end
        end
        DRAIN: begin
          if (drop_cnt_d == '0) begin
            state_q     <= FETCH;
            req_valid_q <= credit_ok;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.queue_level    = q_level;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    bus.if_valid = 1'b0;
    bus.if_instr = NOP_INSTR;
    bus.if_pc    = '0;
    if (!q_empty) begin
      bus.if_valid = 1'b1;
      bus.if_instr = q_rdata.instr;
      bus.if_pc    = q_rdata.pc;
    end else if (bypass) begin
      bus.if_valid = 1'b1;
      bus.if_instr = bus.imem_rsp_data;
      bus.if_pc    = pc_head;
    end
  end

  rsp_without_request_a : assert property (@(posedge clk) disable iff (!reset)
    !(bus.imem_rsp_valid && (state_q == FETCH) && pc_empty));

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: streaming, stall, redirects, drain, PC wrap and the bypass build.
module tb_riscv_fetch_queue;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  riscv_fetch_queue_if #(.DEPTH(4)) bus ();
  riscv_fetch_queue_if #(.DEPTH(4)) wbus ();

  riscv_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  riscv_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk  (clk),
    .reset(rst_n),
    .bus  (wbus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: records handshakes, answers in order after lat edges.
  logic [31:0] hs_addr_q[$];
  int          hs_due_q[$];
  int          edge_cnt = 0;
  int          lat      = 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      hs_addr_q.delete();
      hs_due_q.delete();
      edge_cnt = 0;
    end else begin
      edge_cnt = edge_cnt + 1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        hs_addr_q.push_back(bus.imem_req_addr);
        hs_due_q.push_back(edge_cnt + lat);
      end
    end
  end

  always @(negedge clk) begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    if (rst_n && hs_due_q.size() > 0 && hs_due_q[0] <= edge_cnt + 1) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = imem_word(hs_addr_q[0]);
      void'(hs_addr_q.pop_front());
      void'(hs_due_q.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.stall           = 1'b0;
    wbus.imem_req_ready = 1'b1;
    wbus.imem_rsp_valid = 1'b0;
    wbus.imem_rsp_data  = 32'h0;
    wbus.redirect       = 1'b0;
    wbus.redirect_pc    = 32'h0;
    wbus.stall          = 1'b0;
    step();
    step();

    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_instr", bus.if_instr, 32'h0000_0013);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_level", 32'(bus.queue_level), 32'd0);
    check("rst_wrap_addr", wbus.imem_req_addr, 32'hFFFF_FFF8);

    rst_n = 1'b1;
    step();  // edge 1
    check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("first_req_addr", bus.imem_req_addr, 32'h0);
    check("wrap_addr_0", wbus.imem_req_addr, 32'hFFFF_FFF8);

`ifdef IF_BYPASS_EN
    step();  // edge 2; response for 0x0 is on the bus now
    check("byp_if_valid", 32'(bus.if_valid), 32'd1);
    check("byp_if_pc", bus.if_pc, 32'h0);
    check("byp_if_instr", bus.if_instr, imem_word(32'h0));
    check("byp_level", 32'(bus.queue_level), 32'd0);
    step();  // edge 3
    check("byp_if_pc_next", bus.if_pc, 32'h4);
    check("byp_level_next", 32'(bus.queue_level), 32'd0);
    check("wrap_addr_2", wbus.imem_req_addr, 32'h0000_0000);
`else
    step();  // edge 2
    check("second_req_addr", bus.imem_req_addr, 32'h4);
    check("lat_if_valid_low", 32'(bus.if_valid), 32'd0);
    check("wrap_addr_1", wbus.imem_req_addr, 32'hFFFF_FFFC);
    step();  // edge 3
    check("stream_if_valid", 32'(bus.if_valid), 32'd1);
    check("stream_if_pc_0", bus.if_pc, 32'h0);
    check("stream_if_instr_0", bus.if_instr, imem_word(32'h0));
    check("wrap_addr_2", wbus.imem_req_addr, 32'h0000_0000);
    for (int k = 4; k <= 7; k++) begin
      step();
      check("stream_if_pc", bus.if_pc, 32'(4 * (k - 3)));
    end

    // Stall for six edges: the queue fills to DEPTH and issue stops on credit.
    bus.stall = 1'b1;
    for (int k = 8; k <= 13; k++) step();
    check("stall_level", 32'(bus.queue_level), 32'd4);
    check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("stall_if_pc", bus.if_pc, 32'h10);
    check("stall_if_valid", 32'(bus.if_valid), 32'd1);
    bus.stall = 1'b0;
    for (int k = 14; k <= 18; k++) begin
      step();
      check("resume_if_pc", bus.if_pc, 32'(20 + 4 * (k - 14)));
    end

    // Let the queue run dry with memory not accepting.
    bus.imem_req_ready = 1'b0;
    for (int k = 19; k <= 22; k++) step();
    check("dry_if_valid", 32'(bus.if_valid), 32'd0);
    check("dry_if_instr", bus.if_instr, 32'h0000_0013);
    check("dry_level", 32'(bus.queue_level), 32'd0);
    check("dry_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("dry_req_addr", bus.imem_req_addr, 32'h30);

    // Two requests in flight at 3-cycle latency, then redirect to 0x100.
    lat = 3;
    bus.imem_req_ready = 1'b1;
    step();  // edge 23
    step();  // edge 24
    bus.imem_req_ready = 1'b0;
    bus.redirect       = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();  // edge 25
    check("redir_if_valid", 32'(bus.if_valid), 32'd0);
    check("redir_drain_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.redirect       = 1'b0;
    bus.imem_req_ready = 1'b1;
    lat                = 1;
    step();  // edge 26
    check("drain_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("drain_if_valid", 32'(bus.if_valid), 32'd0);
    step();  // edge 27
    check("refetch_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("refetch_req_addr", bus.imem_req_addr, 32'h100);
    check("refetch_if_valid_low", 32'(bus.if_valid), 32'd0);
    step();  // edge 28
    check("refetch_if_valid_wait", 32'(bus.if_valid), 32'd0);
    step();  // edge 29
    check("target_if_valid", 32'(bus.if_valid), 32'd1);
    check("target_if_pc", bus.if_pc, 32'h100);
    check("target_if_instr", bus.if_instr, imem_word(32'h100));

    // Misaligned redirect with a handshake and a response in the same cycle, then a second redirect.
    lat             = 3;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h203;
    step();  // edge 30
    check("misalign_addr", bus.imem_req_addr, 32'h200);
    check("misalign_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("misalign_if_valid", 32'(bus.if_valid), 32'd0);
    check("misalign_level", 32'(bus.queue_level), 32'd0);
    bus.redirect_pc = 32'h40;
    step();  // edge 31
    check("double_redir_addr", bus.imem_req_addr, 32'h40);
    check("double_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.redirect = 1'b0;
    lat          = 1;
    step();  // edge 32
    check("double_drain_req_valid", 32'(bus.imem_req_valid), 32'd0);
    step();  // edge 33
    check("double_refetch_valid", 32'(bus.imem_req_valid), 32'd1);
    check("double_refetch_addr", bus.imem_req_addr, 32'h40);
    check("double_if_valid_low", 32'(bus.if_valid), 32'd0);
    step();  // edge 34
    check("double_if_valid_wait", 32'(bus.if_valid), 32'd0);
    step();  // edge 35
    check("double_if_valid", 32'(bus.if_valid), 32'd1);
    check("double_if_pc", bus.if_pc, 32'h40);

    // Redirect while stalled: the flush still happens.
    bus.stall = 1'b1;
    step();  // edge 36
    step();  // edge 37
    check("stall2_level", 32'(bus.queue_level), 32'd3);
    check("stall2_if_pc", bus.if_pc, 32'h40);
    check("stall2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    step();  // edge 38
    check("stall_redir_if_valid", 32'(bus.if_valid), 32'd0);
    check("stall_redir_level", 32'(bus.queue_level), 32'd0);
    check("stall_redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("stall_redir_addr", bus.imem_req_addr, 32'h300);
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    step();  // edge 39
    check("stall_redir_wait", 32'(bus.if_valid), 32'd0);
    step();  // edge 40
    check("stall_redir_target_pc", bus.if_pc, 32'h300);
    check("stall_redir_target_instr", bus.if_instr, imem_word(32'h300));
    step();  // edge 41
    check("stall_redir_next_pc", bus.if_pc, 32'h304);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
